// File: rtl/ula_pkg.sv
// ula_pkg: shared encodings for the sequential ULA.
//   op_e    : operation select (sum, sub, mult, div)
//   state_e : control FSM states of ula_seq
package ula_pkg;

  typedef enum logic [1:0] {
    OP_SUM  = 2'd0,
    OP_SUB  = 2'd1,
    OP_MULT = 2'd2,
    OP_DIV  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/ula_iter_core.sv
// ula_iter_core: shared iterative datapath for mult (shift-add) and div (restoring).
// Both operations use the same hi/lo shift pair and iteration counter.
//   clk, rst_n  : clock, asynchronous active-low reset
//   start_i     : load hi=0, lo=a_i, counter=W-1
//   step_i      : perform one iteration
//   is_div_i    : 1 selects restoring division, 0 selects shift-add multiply
//   a_i, b_i    : operand A (loaded on start), operand B (held stable by the caller)
//   last_o      : the current step is the final one
//   hi_next_o   : post-step hi (mult: product high half, div: remainder)
//   lo_next_o   : post-step lo (mult: product low half, div: quotient)
module ula_iter_core #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         step_i,
  input  logic         is_div_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         last_o,
  output logic [W-1:0] hi_next_o,
  output logic [W-1:0] lo_next_o
);

  localparam int unsigned CntW = $clog2(W);

  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [W:0]   mul_sum;
  logic [W-1:0] mul_hi, mul_lo;
  logic [W:0]   div_shift;
  logic         div_ge;
  logic [W-1:0] div_diff;
  logic [W-1:0] div_hi, div_lo;
  logic [W-1:0] step_hi, step_lo;

  always_comb begin
    // Multiply: add B to the high half when the low bit is set, then shift the pair right.
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_i} : '0);
    mul_hi  = mul_sum[W:1];
    mul_lo  = {mul_sum[0], lo_q[W-1:1]};

    // Divide: shift the next dividend bit into the partial remainder and try subtracting B.
    // The partial remainder stays below B, so a W-bit difference is exact when it is taken.
    div_shift = {hi_q, lo_q[W-1]};
    div_ge    = (div_shift >= {1'b0, b_i});
    div_diff  = div_shift[W-1:0] - b_i;
    div_hi    = div_ge ? div_diff : div_shift[W-1:0];
    div_lo    = {lo_q[W-2:0], div_ge};

    step_hi = is_div_i ? div_hi : mul_hi;
    step_lo = is_div_i ? div_lo : mul_lo;

    hi_d  = hi_q;
    lo_d  = lo_q;
    cnt_d = cnt_q;
    if (start_i) begin
      hi_d  = '0;
      lo_d  = a_i;
      cnt_d = CntW'(W - 1);
    end else if (step_i) begin
      hi_d = step_hi;
      lo_d = step_lo;
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      cnt_q <= cnt_d;
    end
  end

  assign last_o    = (cnt_q == '0);
  assign hi_next_o = step_hi;
  assign lo_next_o = step_lo;

endmodule

// File: rtl/ula_seq.sv
// ula_seq: sequential W-bit ULA (sum, sub, mult, div) with a start/done handshake.
// Sum/sub and div-by-zero finish in one cycle; mult/div iterate W cycles in ula_iter_core.
// All outputs are registered and held until the next accepted operation writes them.
//   clk, rst_n   : clock, asynchronous active-low reset
//   start        : request, sampled only in IDLE
//   op           : 0 sum, 1 sub, 2 mult, 3 div
//   a, b         : unsigned operands
//   busy         : operation iterating
//   done         : one-cycle pulse with the new result
//   result       : sum / |a-b| / product / quotient (zero-extended, 2W bits)
//   remainder    : div remainder, 0 otherwise
//   carry        : sum carry-out, or mult product wider than W bits
//   neg          : sub with b > a
//   dbz          : div with b == 0
//   zero         : result == 0
module ula_seq
  import ula_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic [W-1:0]   remainder,
  output logic           carry,
  output logic           neg,
  output logic           dbz,
  output logic           zero
);

  localparam int unsigned RW = 2 * W;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  logic [W-1:0]  b_q, b_d;
  logic [RW-1:0] result_q, result_d;
  logic [W-1:0]  remainder_q, remainder_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          carry_q, carry_d;
  logic          neg_q, neg_d;
  logic          dbz_q, dbz_d;
  logic          zero_q, zero_d;

  op_e           op_in;
  logic [W:0]    sum_w;
  logic          sub_neg;
  logic [W-1:0]  sub_mag;
  logic [RW-1:0] prod;

  logic          core_start, core_step, core_last;
  logic [W-1:0]  core_hi, core_lo;

  assign op_in   = op_e'(op);
  assign sum_w   = {1'b0, a} + {1'b0, b};
  assign sub_neg = (b > a);
  assign sub_mag = sub_neg ? (b - a) : (a - b);
  assign prod    = {core_hi, core_lo};

  ula_iter_core #(
    .W (W)
  ) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (core_start),
    .step_i    (core_step),
    .is_div_i  (op_q == OP_DIV),
    .a_i       (a),
    .b_i       (b_q),
    .last_o    (core_last),
    .hi_next_o (core_hi),
    .lo_next_o (core_lo)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    b_d         = b_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    carry_d     = carry_q;
    neg_d       = neg_q;
    dbz_d       = dbz_q;
    zero_d      = zero_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    core_start  = 1'b0;
    core_step   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d = op_in;
          b_d  = b;
          unique case (op_in)
            OP_SUM: begin
              result_d    = RW'(sum_w);
              remainder_d = '0;
              carry_d     = sum_w[W];
              neg_d       = 1'b0;
              dbz_d       = 1'b0;
              zero_d      = (sum_w == '0);
              done_d      = 1'b1;
              state_d     = ST_DONE;
            end
            OP_SUB: begin
              result_d    = RW'(sub_mag);
              remainder_d = '0;
              carry_d     = 1'b0;
              neg_d       = sub_neg;
              dbz_d       = 1'b0;
              zero_d      = (sub_mag == '0);
              done_d      = 1'b1;
              state_d     = ST_DONE;
            end
            OP_MULT: begin
              core_start = 1'b1;
              busy_d     = 1'b1;
              state_d    = ST_CALC;
            end
            OP_DIV: begin
              if (b == '0) begin
                result_d    = '1;
                remainder_d = a;
                carry_d     = 1'b0;
                neg_d       = 1'b0;
                dbz_d       = 1'b1;
                zero_d      = 1'b0;
                done_d      = 1'b1;
                state_d     = ST_DONE;
              end else begin
                core_start = 1'b1;
                busy_d     = 1'b1;
                state_d    = ST_CALC;
              end
            end
            default: ;
          endcase
        end
      end
      ST_CALC: begin
        core_step = 1'b1;
        if (core_last) begin
          // Outputs take the core's post-step value on this final edge.
          if (op_q == OP_MULT) begin
            result_d    = prod;
            remainder_d = '0;
            carry_d     = |core_hi;
            zero_d      = (prod == '0);
          end else begin
            result_d    = RW'(core_lo);
            remainder_d = core_hi;
            carry_d     = 1'b0;
            zero_d      = (core_lo == '0);
          end
          neg_d   = 1'b0;
          dbz_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          busy_d = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_SUM;
      b_q         <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      carry_q     <= 1'b0;
      neg_q       <= 1'b0;
      dbz_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      b_q         <= b_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      carry_q     <= carry_d;
      neg_q       <= neg_d;
      dbz_q       <= dbz_d;
      zero_q      <= zero_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign remainder = remainder_q;
  assign carry     = carry_q;
  assign neg       = neg_q;
  assign dbz       = dbz_q;
  assign zero      = zero_q;

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
Parametrised, sequential successor to the team's 4-bit combinational ULA. It supports the same four operations (sum, sub, mult, div) at width W, using a start/done handshake.
- Sum and sub complete in one cycle.
- Mult uses an iterative shift-add datapath; div uses an iterative restoring-division datapath. Both take W iteration cycles.
- Outputs are registered and held until the next accepted operation.
- Sits between the register file / control FSM and the result bus of the embedded datapath.

Parameters:
W, 4, operand width in bits (legal range 2..32)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
op  in  2  operation: 0 sum, 1 sub, 2 mult, 3 div
a  in  W  operand A (unsigned)
b  in  W  operand B (unsigned)
busy  out  1  high while an operation is in progress (CALC)
done  out  1  one-cycle pulse when result is valid
result  out  2W  sum / |a-b| / product / quotient (zero-extended)
remainder  out  W  div remainder; 0 for other ops
carry  out  1  sum: result[W]; mult: product exceeds W bits; else 0
neg  out  1  sub: 1 when b > a; else 0
dbz  out  1  div with b == 0
zero  out  1  result == 0

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, result, remainder, carry, neg, dbz, zero all 0; iteration counter 0.
- Reset released mid-operation: the operation is abandoned and no done is produced.
- FSM states: IDLE, CALC, DONE.
- IDLE, start=1: a, b, op are latched into internal registers. Input changes afterwards have no effect.
  - op sum/sub → DONE. Result is computed on this edge; done is high in the next cycle (latency 1).
  - op mult/div with b != 0 → CALC, counter = W-1.
  - op div with b == 0 → DONE. result = all ones (2W bits), remainder = a, dbz = 1.
- CALC: one iteration per cycle; busy = 1.
  - When counter == 0, write the outputs and go to DONE.
  - mult/div latency is W+1 cycles from the start edge to the done cycle.
- DONE: done = 1 for exactly one cycle, then → IDLE. start during DONE is ignored.
- start during CALC or DONE is ignored: not queued, and no error is raised.
- The previous result and flags remain stable during a new operation until its results are written on its final edge.
- busy is low in IDLE and DONE.
- Arithmetic (all unsigned):
  - sum: result = a+b in W+1 bits.
  - sub: result = |a-b|; neg = (b > a). When a == b: result 0, neg 0, zero 1.
  - mult: full 2W-bit product.
  - div: W-bit quotient in result[W-1:0]; remainder in remainder.
- Flags not relevant to the current op are written as 0 on the same edge as the result.
- Back-to-back operations: start may be asserted in the IDLE cycle immediately after done.

Decomposition:
- Shared package ula_pkg holds:
  - op encodings OP_SUM=2'd0, OP_SUB=2'd1, OP_MULT=2'd2, OP_DIV=2'd3;
  - FSM state encodings ST_IDLE, ST_CALC, ST_DONE.
- One sub-module, ula_iter_core, holds the shared shift register / accumulator / counter.
  - It performs one shift-add (mult) or one restore-subtract (div) step per enable.
  - It has its own start/last handshake with the top FSM.
- The top module holds the FSM, operand latches, the single-cycle sum/sub path, and the output registers.

Test Plan:
- W=4, sum a=9, b=8 → done 1 cycle after start; result=17, carry=1, zero=0. Then a=0, b=0 → result 0, zero=1.
- W=4, sub a=3, b=7 → result=4, neg=1. Then sub a=7, b=7 → result=0, neg=0, zero=1.
- W=4, mult a=15, b=15 → busy for 4 cycles, done at cycle 5; result=225, carry=1. Toggling a/b during CALC has no effect.
- W=4, div a=13, b=4 → result=3, remainder=1. div a=13, b=0 → done after 1 cycle, result=255, remainder=13, dbz=1.
- W=8, mult a=200, b=3 → result=600 at cycle 9. start pulsed at cycles 3 and 9 → ignored; exactly one done.
- W=4, assert rst_n=0 mid-div (cycle 2) → all outputs 0 immediately, asynchronously. After release: no done pulse; state IDLE; a new sum is accepted normally.
